// File: rtl/fa_pkg.sv
// Shared types for the chunked serial adder.
// Holds the FSM encoding and counter sizing helper.
package fa_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fa_chunk.sv
// Combinational CHUNK-bit ripple adder slice.
// Also exposes the carry into its MSB for overflow.
module fa_chunk
  import fa_pkg::*;
#(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         ci,
  output logic [W-1:0] s,
  output logic         co,
  output logic         cm
);

  always_comb begin
    logic c;
    c  = ci;
    s  = '0;
    cm = ci;
    for (int i = 0; i < W; i++) begin
      if (i == W - 1) cm = c;
      s[i] = a[i] ^ b[i] ^ c;
      c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    co = c;
  end

endmodule

// File: rtl/fa_serial.sv
// Serial adder/subtractor: CHUNK bits per clock over N cycles.
// Results are registered at the RUN-to-DONE transition.
module fa_serial
  import fa_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic [WIDTH-1:0] s,
  output logic             co,
  output logic             ovf,
  output logic             busy,
  output logic             done
);

  localparam int N  = WIDTH / CHUNK;
  localparam int CW = cnt_w(N);

  state_t           state;
  state_t           state_nx;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] full;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic [CHUNK-1:0] ca;
  logic [CHUNK-1:0] cb;
  logic [CHUNK-1:0] cs;
  logic             cc;
  logic             cm;
  logic             last;
  logic             take;

  assign ca   = op_a[int'(cnt)*CHUNK +: CHUNK];
  assign cb   = op_b[int'(cnt)*CHUNK +: CHUNK];
  assign last = (cnt == CW'(N - 1));
  assign take = start && (state != RUN);

  fa_chunk #(
    .W (CHUNK)
  ) u_chunk (
    .a  (ca),
    .b  (cb),
    .ci (carry),
    .s  (cs),
    .co (cc),
    .cm (cm)
  );

  // Top chunk is still in flight on the final edge; merge it here.
  always_comb begin
    full = acc;
    full[WIDTH-1 -: CHUNK] = cs;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (last) state_nx = DONE;
      DONE:    state_nx = start ? RUN : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_a  <= '0;
      op_b  <= '0;
      acc   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      s     <= '0;
      co    <= 1'b0;
      ovf   <= 1'b0;
    end else if (take) begin
      op_a  <= a;
      op_b  <= sub ? ~b : b;
      carry <= sub ? 1'b1 : ci;
      cnt   <= '0;
    end else if (state == RUN) begin
      acc[int'(cnt)*CHUNK +: CHUNK] <= cs;
      carry <= cc;
      cnt   <= cnt + CW'(1);
      if (last) begin
        s   <= full;
        co  <= cc;
        ovf <= cc ^ cm;
      end
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule
